interval_timer_ctrl: RTL and testbench

//  Sequencer wrapped around one instance of the team Counter datapath.

---
 rtl/timer_pkg.sv | 13 +
 rtl/interval_timer_ctrl_counter.sv | 28 ++
 rtl/interval_timer_ctrl.sv | 109 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and default datapath width.
package timer_pkg;

   localparam int unsigned DEFAULT_BITS = 8;

   // 2'd3 is unused and recovers to StIdle in the FSM default branch.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } timer_state_e;

endpackage

// File: rtl/interval_timer_ctrl_counter.sv
// Team Counter datapath: up-counter with synchronous clear (reset) and count enable.
module interval_timer_ctrl_counter
   import timer_pkg::*;
#(
   parameter int unsigned BITS = DEFAULT_BITS
) (
   input  logic            CLK,
   input  logic            enable,
   input  logic            reset,
   output logic [BITS-1:0] count,
   output logic            overflow
);

   logic [BITS-1:0] count_q;

   // No asynchronous reset: the controller holds reset high while idle.
   always_ff @(posedge CLK) begin
      if (reset) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + BITS'(1);
      end
   end

   assign count    = count_q;
   assign overflow = enable && !reset && (&count_q);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer around one Counter; emits a one-cycle done pulse after a period.
// Optional prescaler (PRESCALE cycles per count step) compiled in with TIMER_PRESCALE_EN.
module interval_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned BITS     = DEFAULT_BITS,
   parameter int unsigned PRESCALE = 4
) (
   input  logic            CLK,
   input  logic            reset_n,
   input  logic            start,
   input  logic            stop,
   input  logic [BITS-1:0] period,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] count_out
);

   timer_state_e    state_q, state_d;
   logic [BITS-1:0] period_q;
   logic            load_period;
   logic            step;
   logic            en;
   logic            clr;
   logic [BITS-1:0] count;
   logic            unused_ovf;

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PsW-1:0] ps_q;

   assign step = (ps_q == PsW'(PRESCALE - 1));

   // Held at zero outside RUN so every interval starts a fresh prescale period.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         ps_q <= '0;
      end else if ((state_q != StRun) || step) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_q + PsW'(1);
      end
   end
`else
   logic unused_prescale;

   assign step             = 1'b1;
   assign unused_prescale  = ^PRESCALE;
`endif

   always_comb begin
      state_d     = state_q;
      load_period = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (stop) begin
               state_d = StIdle;
            end else if (start) begin
               if (period != '0) begin
                  state_d     = StRun;
                  load_period = 1'b1;
               end else begin
                  state_d = StDone;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else if (step && (count == period_q - BITS'(1))) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         period_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_period) begin
            period_q <= period;
         end
      end
   end

   assign clr       = (state_q != StRun);
   assign en        = (state_q == StRun) && step;
   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign count_out = (state_q == StIdle) ? '0 : count;

   interval_timer_ctrl_counter #(
      .BITS (BITS)
   ) u_counter (
      .CLK      (CLK),
      .enable   (en),
      .reset    (clr),
      .count    (count),
      .overflow (unused_ovf)
   );

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: stimulus pushes expected done events, a monitor checks.
module tb_interval_timer_ctrl;

   localparam int BITS = 8;
`ifdef TIMER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic            CLK     = 1'b0;
   logic            reset_n = 1'b0;
   logic            start   = 1'b0;
   logic            stop    = 1'b0;
   logic [BITS-1:0] period  = '0;
   logic            busy;
   logic            done;
   logic [BITS-1:0] count_out;

   always #5 CLK = ~CLK;

   interval_timer_ctrl #(
      .BITS     (BITS),
      .PRESCALE (4)
   ) dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .period    (period),
      .busy      (busy),
      .done      (done),
      .count_out (count_out)
   );

   typedef struct {
      int cyc;
      int cnt;
      int blen;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc   = 0;
   int   brun  = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!reset_n) begin
         brun = 0;
      end else if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("done_count", int'(count_out), e.cnt);
            check("busy_len", brun, e.blen);
         end
         brun = 0;
      end else if (busy) begin
         brun++;
      end else begin
         brun = 0;
      end
   end

   // Returns at the negedge right after the accepting edge E0 (cyc == E0).
   task automatic pulse_start(input int p, input bit expect_done);
      @(negedge CLK);
      start  = 1'b1;
      period = BITS'(p);
      if (expect_done) begin
         if (p != 0) sb.push_back('{cyc + 1 + p * PS, p, p * PS});
         else        sb.push_back('{cyc + 1, 0, 0});
      end
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_count(input int v);
      int n = 0;
      while (int'(count_out) != v && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("reach_count", int'(count_out), v);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      int d1;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d1;
      // Reset state
      tick(3);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_count", int'(count_out), 0);
      reset_n = 1'b1;
      tick(2);

      // Reset mid-RUN: outputs drop without waiting for a clock, no done afterwards
      pulse_start(8, 1'b0);
      wait_count(3);
      check("run_busy", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_count", int'(count_out), 0);
      @(negedge CLK);
      reset_n = 1'b1;
      tick(8 * PS + 4);

      // Basic interval
      pulse_start(5, 1'b1);
      wait_count(2);
      check("p5_busy", int'(busy), 1);
      tick(5 * PS + 3);

      // Abort with stop, then zero-length interval
      pulse_start(10, 1'b0);
      wait_count(4);
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      check("stop_busy", int'(busy), 0);
      check("stop_count", int'(count_out), 0);
      tick(10 * PS + 2);
      pulse_start(0, 1'b1);
      check("p0_busy", int'(busy), 0);
      tick(3);

      // Count stepping (every PS cycles)
      pulse_start(3, 1'b1);
      for (int i = 0; i < 3 * PS; i++) begin
         if (i % PS == 0) check("step_count", int'(count_out), i / PS);
         @(negedge CLK);
      end
      tick(3);

      // Max period, then back-to-back with start held through DONE
      pulse_start(255, 1'b1);
      d1 = cyc + 255 * PS;
      tick(255 * PS - 1);
      start  = 1'b1;
      period = BITS'(3);
      @(negedge CLK);
      check("max_done", int'(done), 1);
      sb.push_back('{d1 + 1 + 3 * PS, 3, 3 * PS});
      @(negedge CLK);
      start  = 1'b0;
      period = BITS'(9);
      check("b2b_busy", int'(busy), 1);
      check("b2b_count", int'(count_out), 0);
      tick(3 * PS + 3);

      // Start and stop together in IDLE: stop wins
      @(negedge CLK);
      start  = 1'b1;
      stop   = 1'b1;
      period = BITS'(5);
      @(negedge CLK);
      start = 1'b0;
      stop  = 1'b0;
      check("ss_busy", int'(busy), 0);
      check("ss_done", int'(done), 0);
      tick(5 * PS + 3);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
